// File: rtl/clk_gen_cfg_seq.sv
// Bus-master sequencer that reprograms the clk_gen register slave: disable, write divider,
// read it back, optionally re-enable and verify, then report done/err with a result code.
module clk_gen_cfg_seq #(
  parameter logic [3:0]  ADR_STATUS  = 4'h0,
  parameter logic [3:0]  ADR_DIV     = 4'h1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] div_i,
  input  logic       en_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [3:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_DIV = 2'b01;
  localparam logic [1:0] CODE_ST  = 2'b10;
  localparam logic [1:0] CODE_TMO = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} state_e;
  typedef enum logic [2:0] {
    STEP_DIS,     // wr STATUS <= 00
    STEP_WR_DIV,  // wr DIV <= div
    STEP_RD_DIV,  // rd DIV, compare against div
    STEP_ENA,     // wr STATUS <= 01
    STEP_RD_ST    // rd STATUS, check enable bit
  } step_e;

  state_e           state_q, state_d;
  step_e            step_q,  step_d;
  logic [7:0]       div_q,   div_d;
  logic             en_q,    en_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       code_q,  code_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_DIS;
      div_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      code_q  <= CODE_OK;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      div_q   <= div_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // NOTE: every next-state signal gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    div_d   = div_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_ISSUE;
          step_d  = STEP_DIS;
          div_d   = div_i;
          en_d    = en_i;
          code_d  = CODE_OK;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (ack_i) begin
          state_d = ST_ISSUE;
          unique case (step_q)
            STEP_DIS:    step_d = STEP_WR_DIV;
            STEP_WR_DIV: step_d = STEP_RD_DIV;
            STEP_RD_DIV: begin
              // A bad read-back leaves the generator disabled on purpose.
              if (dat_i != div_q) begin
                state_d = ST_FIN;
                code_d  = CODE_DIV;
              end else if (en_q) begin
                step_d = STEP_ENA;
              end else begin
                state_d = ST_FIN;
              end
            end
            STEP_ENA:    step_d = STEP_RD_ST;
            default: begin
              state_d = ST_FIN;
              if (!dat_i[0]) code_d = CODE_ST;
            end
          endcase
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FIN;
          code_d  = CODE_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus fields are decoded from the registered step, so they stay stable through WAIT.
  always_comb begin
    stb_o = (state_q == ST_ISSUE);
    we_o  = 1'b0;
    adr_o = '0;
    dat_o = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      unique case (step_q)
        STEP_DIS: begin
          we_o  = 1'b1;
          adr_o = ADR_STATUS;
        end
        STEP_WR_DIV: begin
          we_o  = 1'b1;
          adr_o = ADR_DIV;
          dat_o = div_q;
        end
        STEP_RD_DIV: adr_o = ADR_DIV;
        STEP_ENA: begin
          we_o  = 1'b1;
          adr_o = ADR_STATUS;
          dat_o = 8'h01;
        end
        default: adr_o = ADR_STATUS;
      endcase
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_FIN);
  assign err_o      = (state_q == ST_FIN) && (code_q != CODE_OK);
  assign err_code_o = code_q;

endmodule

// File: tb/tb_clk_gen_cfg_seq.sv
// Directed bench for clk_gen_cfg_seq: a table of whole-sequence scenarios against a small
// bus slave model, plus hand-written sequences for idle acks, held requests and reset.
module tb_clk_gen_cfg_seq;

  localparam logic [3:0] ADR_S = 4'h0;
  localparam logic [3:0] ADR_D = 4'h1;
  localparam int         MAX_CYC = 60;

  logic       clk = 1'b0;
  logic       rst_i, req_i, en_i, ack_i;
  logic [7:0] div_i, dat_i;
  logic       busy_o, done_o, err_o, stb_o, we_o;
  logic [1:0] err_code_o;
  logic [3:0] adr_o;
  logic [7:0] dat_o;

  int n_cmp = 0;
  int n_mis = 0;

  clk_gen_cfg_seq #(.ADR_STATUS(ADR_S), .ADR_DIV(ADR_D), .ACK_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .div_i(div_i), .en_i(en_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] div;
    logic       en;
    logic [7:0] rd_div;    // slave data returned for a DIV read
    logic [7:0] rd_st;     // slave data returned for a STATUS read
    int         noack;     // transaction index the slave never acks (-1: none)
    int         exp_stb;
    int         exp_done;  // cycle of done_o, counting the cycle after accept as 1
    logic [1:0] exp_code;
    bit         exp_st01;  // STATUS <= 01 expected on the bus
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_seq(input int idx, input vec_t v, input bit hold);
    logic [12:0] exp_tx[5];
    logic [12:0] ptx = '0;
    int  cyc = 0, nstb = 0, ntx = 0, pidx = -1, done_cyc = -1;
    bit  prev_stb = 0, seen_done = 0, st01 = 0, busy_bad = 0, hold_bad = 0;
    exp_tx[0] = {1'b1, ADR_S, 8'h00};
    exp_tx[1] = {1'b1, ADR_D, v.div};
    exp_tx[2] = {1'b0, ADR_D, 8'h00};
    exp_tx[3] = {1'b1, ADR_S, 8'h01};
    exp_tx[4] = {1'b0, ADR_S, 8'h00};
    @(negedge clk);
    req_i = 1'b1; div_i = v.div; en_i = v.en; ack_i = 1'b0;
    @(posedge clk);
    while (!seen_done && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("v%0d busy_after_accept", idx), busy_o, 1);
        check($sformatf("v%0d code_cleared", idx), err_code_o, 0);
      end
      if (!busy_o) busy_bad = 1;
      if (prev_stb && {we_o, adr_o, dat_o} !== ptx) hold_bad = 1;
      if (stb_o) begin
        nstb++;
        if (ntx < 5) check($sformatf("v%0d tx%0d", idx, ntx), {we_o, adr_o, dat_o}, exp_tx[ntx]);
        if (we_o && adr_o == ADR_S && dat_o == 8'h01) st01 = 1;
        ptx  = {we_o, adr_o, dat_o};
        pidx = ntx;
        ntx++;
      end
      if (done_o) begin
        seen_done = 1;
        done_cyc  = cyc;
        check($sformatf("v%0d err_o", idx), err_o, (v.exp_code != 2'b00));
        check($sformatf("v%0d code", idx), err_code_o, v.exp_code);
      end
      // Slave acks in the cycle after each strobe unless told to stay silent.
      ack_i = 1'b0;
      dat_i = 8'h00;
      if (prev_stb && pidx != v.noack) begin
        ack_i = 1'b1;
        if (!ptx[12]) dat_i = (ptx[11:8] == ADR_D) ? v.rd_div : v.rd_st;
      end
      prev_stb = stb_o;
      if (!hold) req_i = 1'b0;
      div_i = ~v.div;
      en_i  = ~v.en;
    end
    ack_i = 1'b0;
    check($sformatf("v%0d done_seen", idx), seen_done, 1);
    check($sformatf("v%0d done_cyc", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d stb_count", idx), nstb, v.exp_stb);
    check($sformatf("v%0d st01_written", idx), st01, v.exp_st01);
    check($sformatf("v%0d busy_gap", idx), busy_bad, 0);
    check($sformatf("v%0d wait_hold", idx), hold_bad, 0);
    @(negedge clk);
    check($sformatf("v%0d post_done", idx), {done_o, busy_o, err_o}, 3'b000);
    check($sformatf("v%0d code_held", idx), err_code_o, v.exp_code);
  endtask

  initial begin
    int quiet;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    //             div    en    rd_div rd_st  noack stb done code   st01
    vecs[0] = '{8'h2A, 1'b1, 8'h2A, 8'h01, -1, 5, 11, 2'b00, 1'b1};
    vecs[1] = '{8'h05, 1'b0, 8'h05, 8'h01, -1, 3,  7, 2'b00, 1'b0};
    vecs[2] = '{8'h2A, 1'b1, 8'h2B, 8'h01, -1, 3,  7, 2'b01, 1'b0};
    vecs[3] = '{8'h2A, 1'b1, 8'h2A, 8'h01,  1, 2, 20, 2'b11, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 8'h7F, 8'hFE, -1, 5, 11, 2'b10, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 8'hFF, -1, 5, 11, 2'b00, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 8'h00, 8'h01,  2, 3, 22, 2'b11, 1'b0};
    vecs[7] = '{8'h33, 1'b1, 8'h33, 8'h01,  0, 1, 18, 2'b11, 1'b0};

    rst_i = 1'b1; req_i = 1'b0; div_i = 8'h00; en_i = 1'b0; ack_i = 1'b0; dat_i = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {stb_o, busy_o, done_o, err_o, err_code_o, we_o, adr_o, dat_o}, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_seq(i, vecs[i], 1'b0);

    // Leave a non-zero code behind, then show acks in IDLE do nothing and the code is held.
    run_seq(20, vecs[2], 1'b0);
    quiet = 0;
    for (int c = 0; c < 3; c++) begin
      ack_i = 1'b1; dat_i = 8'hFF;
      @(negedge clk);
      if (busy_o || stb_o || done_o) quiet++;
    end
    ack_i = 1'b0; dat_i = 8'h00;
    check("idle_ack_ignored", quiet, 0);
    check("idle_code_held", err_code_o, 2'b01);

    // Request held high through a whole sequence: no restart while busy, re-trigger after IDLE.
    run_seq(21, vecs[0], 1'b1);
    @(negedge clk);
    check("retrigger_stb", {stb_o, busy_o}, 2'b11);
    check("retrigger_code_clear", err_code_o, 2'b00);
    req_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("retrigger_reset_idle", busy_o, 0);

    // Reset during the DIV read-back WAIT.
    @(negedge clk);
    req_i = 1'b1; div_i = 8'h2A; en_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_i = 1'b0;
      ack_i = (c == 2 || c == 4);
      dat_i = 8'h00;
      if (c == 5) check("rst_s2_issue", {stb_o, we_o, adr_o}, {1'b1, 1'b0, ADR_D});
      if (c == 6) begin
        check("rst_s2_wait", {stb_o, busy_o, we_o, adr_o}, {1'b0, 1'b1, 1'b0, ADR_D});
        rst_i = 1'b1;
      end
    end
    @(negedge clk);
    check("rst_mid_outputs",
          {stb_o, busy_o, done_o, err_o, err_code_o, we_o, adr_o, dat_o}, 0);
    rst_i = 1'b0;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (stb_o || done_o || busy_o) quiet++;
    end
    check("rst_no_resume", quiet, 0);
    run_seq(30, vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
